// File: rtl/wakeup_arbiter.sv
`default_nettype none
// ============================================================================
// wakeup_arbiter : per-FU result FIFOs, round-robin grant onto one registered
//                  wakeup/broadcast bus.
// Revision       : 1.0
// ============================================================================
module wakeup_arbiter #(
   parameter int  NUM_REQ    = 3,
   parameter int  FIFO_DEPTH = 2,
   parameter int  TAG_W      = 6,
   parameter int  DATA_W     = 32,
   localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_W-1:0] req_value,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      wakeup_active,
   output logic [TAG_W-1:0]          wakeup_tag,
   output logic [DATA_W-1:0]         wakeup_value,
   output logic [SRC_W-1:0]          wakeup_src,
   output logic                      idle
);

   localparam int               PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int               CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

   logic [CNT_W-1:0]  count_q  [NUM_REQ];
   logic [CNT_W-1:0]  count_d  [NUM_REQ];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_REQ];
   logic [PTR_W-1:0]  rd_ptr_d [NUM_REQ];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_REQ];
   logic [PTR_W-1:0]  wr_ptr_d [NUM_REQ];
   logic [TAG_W-1:0]  tag_mem_q   [NUM_REQ][FIFO_DEPTH];
   logic [DATA_W-1:0] value_mem_q [NUM_REQ][FIFO_DEPTH];

   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              wakeup_active_q, wakeup_active_d;
   logic [TAG_W-1:0]  wakeup_tag_q, wakeup_tag_d;
   logic [DATA_W-1:0] wakeup_value_q, wakeup_value_d;
   logic [SRC_W-1:0]  wakeup_src_q, wakeup_src_d;

   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   logic               grant_found;
   logic [SRC_W-1:0]   grant_idx;
   int                 scan_idx;
   logic               any_pending;

   // Round-robin scan starting at rr_ptr over the registered FIFO occupancy.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!grant_found && (count_q[scan_idx] != '0)) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(scan_idx);
         end
      end
   end

   always_comb begin
      any_pending = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (count_q[i] != C_FULL);
         // Tag 0 is the hardwired register: handshake completes, nothing is stored.
         push[i] = req_valid[i] && (count_q[i] != C_FULL) &&
                   (req_tag[i*TAG_W +: TAG_W] != '0) && !flush;
         pop[i]  = grant_found && (grant_idx == SRC_W'(i)) && !flush;
         if (count_q[i] != '0) begin
            any_pending = 1'b1;
         end
      end
      idle = !any_pending && !wakeup_active_q;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         count_d[i]  = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
         wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
         if (flush) begin
            count_d[i]  = '0;
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = rd_ptr_q[i];
         end
      end

      rr_ptr_d        = rr_ptr_q;
      wakeup_active_d = grant_found && !flush;
      wakeup_tag_d    = wakeup_tag_q;
      wakeup_value_d  = wakeup_value_q;
      wakeup_src_d    = wakeup_src_q;
      if (wakeup_active_d) begin
         wakeup_tag_d   = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
         wakeup_value_d = value_mem_q[grant_idx][rd_ptr_q[grant_idx]];
         wakeup_src_d   = grant_idx;
         rr_ptr_d       = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            count_q[i]  <= '0;
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
         end
         rr_ptr_q        <= '0;
         wakeup_active_q <= 1'b0;
         wakeup_tag_q    <= '0;
         wakeup_value_q  <= '0;
         wakeup_src_q    <= '0;
      end else begin
         count_q         <= count_d;
         rd_ptr_q        <= rd_ptr_d;
         wr_ptr_q        <= wr_ptr_d;
         rr_ptr_q        <= rr_ptr_d;
         wakeup_active_q <= wakeup_active_d;
         wakeup_tag_q    <= wakeup_tag_d;
         wakeup_value_q  <= wakeup_value_d;
         wakeup_src_q    <= wakeup_src_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by count/pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (push[i]) begin
            tag_mem_q[i][wr_ptr_q[i]]   <= req_tag[i*TAG_W +: TAG_W];
            value_mem_q[i][wr_ptr_q[i]] <= req_value[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wakeup_active = wakeup_active_q;
   assign wakeup_tag    = wakeup_tag_q;
   assign wakeup_value  = wakeup_value_q;
   assign wakeup_src    = wakeup_src_q;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            assert (!(push[i] && (count_q[i] == C_FULL)))
               else $fatal(1, "push into full FIFO %0d", i);
            for (int a = 0; a < int'(count_q[i]); a++) begin
               for (int j = 0; j < NUM_REQ; j++) begin
                  for (int b = 0; b < int'(count_q[j]); b++) begin
                     if ((i != j) || (a != b)) begin
                        assert (tag_mem_q[i][(int'(rd_ptr_q[i]) + a) % FIFO_DEPTH] !=
                                tag_mem_q[j][(int'(rd_ptr_q[j]) + b) % FIFO_DEPTH])
                           else $fatal(1, "tag pending twice (FIFO %0d and %0d)", i, j);
                     end
                  end
               end
            end
         end
      end
   end

endmodule
`default_nettype wire
